// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control: state codes, opcodes,
// select codes and the control vector. Defining MC_ADDI_EN adds the addi opcode and states.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        alu_op:        ALUOP_ADD,
        alu_src_a:     1'b0,
        alu_src_b:     SRCB_REG,
        pc_source:     PCSRC_ALU,
        iord:          1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        ir_write:      1'b0,
        reg_dst:       1'b0,
        mem_to_reg:    1'b0,
        reg_write:     1'b0,
        pc_write:      1'b0,
        pc_write_cond: 1'b0
    };

    function automatic logic opcode_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MC_ADDI_EN
            OP_ADDI:                              legal = 1'b1;
`endif
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decoder from the main-control state (plus mem_ready for the
// FETCH write strobes) to the full datapath control vector.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Moore decode; only ir_write/pc_write in FETCH look at mem_ready
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end else begin
                    ctrl.ir_write = 1'b0;
                    ctrl.pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
`endif
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM with memory-wait timeout monitor.
// Optional addi support is enabled by defining MC_ADDI_EN.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX_C  = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LAST_C = CW'(MEM_WAIT_MAX - 1);

    state_t        state_r;
    state_t        state_next_s;
    ctrl_t         dec_ctrl_s;
    ctrl_t         ctrl_s;
    logic          in_mem_s;
    logic          wait_hit_s;
    logic          wait_sat_s;
    logic          illegal_s;
    logic [CW-1:0] wait_cnt_r;
    logic          timeout_r;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; opcode is only consulted in DECODE and MEMADR
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_EXEC;
                    OP_BEQ:       state_next_s = S_BRANCH;
                    OP_J:         state_next_s = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_next_s = S_ADDIEX;
`endif
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_EXEC:   state_next_s = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH,
            S_JUMP:   state_next_s = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_next_s = S_ADDIWB;
            S_ADDIWB: state_next_s = S_FETCH;
`endif
            default:  state_next_s = S_FETCH;
        endcase
    end

    assign in_mem_s   = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign wait_sat_s = (wait_cnt_r == WAIT_MAX_C);
    assign wait_hit_s = (MEM_WAIT_MAX != 0) && (wait_cnt_r == WAIT_LAST_C);

    // Wait counter: cleared on every state change, saturates so the timeout fires once per visit
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= in_mem_s && !mem_ready && wait_hit_s;
            if (state_next_s != state_r) begin
                wait_cnt_r <= '0;
            end else if (in_mem_s && !mem_ready && !wait_sat_s) begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_r),
        .mem_ready (mem_ready),
        .ctrl      (dec_ctrl_s)
    );

    // Force every strobe and select low while reset is held
    always_comb begin
        if (reset) begin
            ctrl_s    = CTRL_IDLE;
            illegal_s = 1'b0;
        end else begin
            ctrl_s    = dec_ctrl_s;
            illegal_s = (state_r == S_DECODE) && !opcode_legal(opcode);
        end
    end

    assign alu_op        = ctrl_s.alu_op;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign pc_source     = ctrl_s.pc_source;
    assign iord          = ctrl_s.iord;
    assign mem_read      = ctrl_s.mem_read;
    assign mem_write     = ctrl_s.mem_write;
    assign ir_write      = ctrl_s.ir_write;
    assign reg_dst       = ctrl_s.reg_dst;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign reg_write     = ctrl_s.reg_write;
    assign pc_write      = ctrl_s.pc_write;
    assign pc_write_cond = ctrl_s.pc_write_cond;
    assign illegal_op    = illegal_s;
    assign mem_timeout   = timeout_r && !reset;
    assign state         = state_r;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: builds a per-cycle plan of expected steps from
// instruction recipes and checks every cycle against it.
module tb_mc_main_control;

    localparam int MAXW = 15;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP   = 4'd9;
    localparam logic [3:0] ST_ADDIEX = 4'd10;
    localparam logic [3:0] ST_ADDIWB = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       rst;
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
        logic       tmo;
    } step_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       illegal_op;
        logic       mem_timeout;
    } outs_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] dut_state;

    step_t plan[$];
    step_t cur;
    logic  cur_valid;
    int    n_checks;
    int    n_pass;

    mc_main_control #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout),
        .state         (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
`ifdef MC_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

    // A timeout is seen once, when exactly MAXW wait cycles precede this one in the same visit
    function automatic logic tmo_at(input int prior_waits);
        return (MAXW != 0) && (prior_waits == MAXW);
    endfunction

    task automatic add_step(input logic rst, input logic [3:0] st, input logic rdy,
                            input logic [5:0] op, input logic tmo);
        step_t s;
        s.rst = rst; s.st = st; s.rdy = rdy; s.op = op; s.tmo = tmo;
        plan.push_back(s);
    endtask

    // Memory step with n wait cycles followed by the completing cycle
    task automatic add_mem(input logic [3:0] st, input logic [5:0] op, input int waits);
        for (int k = 0; k < waits; k++) add_step(1'b0, st, 1'b0, op, tmo_at(k));
        add_step(1'b0, st, 1'b1, op, tmo_at(waits));
    endtask

    // Non-memory steps see a mem_ready pattern that must not matter
    task automatic add_plain(input logic [3:0] st, input logic [5:0] op);
        add_step(1'b0, st, plan.size() % 2 == 1, op, 1'b0);
    endtask

    task automatic add_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
        add_mem(ST_FETCH, op, fetch_waits);
        add_plain(ST_DECODE, op);
        if (is_legal(op)) begin
            case (op)
                OP_LW: begin
                    add_plain(ST_MEMADR, op);
                    add_mem(ST_MEMRD, op, mem_waits);
                    add_plain(ST_MEMWB, op);
                end
                OP_SW: begin
                    add_plain(ST_MEMADR, op);
                    add_mem(ST_MEMWR, op, mem_waits);
                end
                OP_R: begin
                    add_plain(ST_EXEC, op);
                    add_plain(ST_ALUWB, op);
                end
                OP_BEQ: add_plain(ST_BRANCH, op);
                OP_J:   add_plain(ST_JUMP, op);
                default: begin
                    add_plain(ST_ADDIEX, op);
                    add_plain(ST_ADDIWB, op);
                end
            endcase
        end
    endtask

    function automatic int count_tmo(input int from);
        int n = 0;
        for (int i = from; i < plan.size(); i++) if (plan[i].tmo) n++;
        return n;
    endfunction

    function automatic outs_t expected(input step_t s);
        outs_t o = '0;
        if (!s.rst) begin
            case (s.st)
                ST_FETCH:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                                 o.ir_write = s.rdy; o.pc_write = s.rdy; end
                ST_DECODE: begin o.alu_src_b = 2'b11; o.illegal_op = !is_legal(s.op); end
                ST_MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
                ST_MEMRD:  begin o.iord = 1'b1; o.mem_read = 1'b1; end
                ST_MEMWB:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
                ST_MEMWR:  begin o.iord = 1'b1; o.mem_write = 1'b1; end
                ST_EXEC:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
                ST_ALUWB:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
                ST_BRANCH: begin o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                                 o.pc_source = 2'b01; o.pc_write_cond = 1'b1; end
                ST_JUMP:   begin o.pc_source = 2'b10; o.pc_write = 1'b1; end
                ST_ADDIEX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
                ST_ADDIWB: begin o.reg_write = 1'b1; end
                default:   o = '0;
            endcase
            o.mem_timeout = s.tmo;
        end
        return o;
    endfunction

    // Per-cycle compare of DUT against the current plan step, away from the active edge
    always @(negedge clk) begin
        if (cur_valid) begin
            outs_t act;
            act = '{alu_op, alu_src_a, alu_src_b, pc_source, iord, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, pc_write, pc_write_cond,
                    illegal_op, mem_timeout};
            check("state", 32'(dut_state), 32'(cur.st));
            check("outputs", 32'(act), 32'(expected(cur)));
        end
    end

    initial begin
        int base;
        n_checks = 0; n_pass = 0;
        reset = 1'b1; opcode = OP_R; mem_ready = 1'b0; cur_valid = 1'b0; cur = '0;

        add_step(1'b1, ST_FETCH, 1'b0, OP_R, 1'b0);
        base = plan.size(); add_instr(OP_LW, 0, 0);  check("lw_len", 32'(plan.size() - base), 32'd5);
        base = plan.size(); add_instr(OP_R, 0, 0);   check("rtype_len", 32'(plan.size() - base), 32'd4);
        base = plan.size(); add_instr(OP_BEQ, 0, 0); check("beq_len", 32'(plan.size() - base), 32'd3);
        base = plan.size(); add_instr(OP_LW, 3, 2);  check("lw_wait_len", 32'(plan.size() - base), 32'd10);
        check("fetch_ready_step", 32'(plan[base + 3].rdy), 32'd1);
        base = plan.size(); add_instr(OP_BAD, 0, 0); check("illegal_len", 32'(plan.size() - base), 32'd2);
        base = plan.size(); add_instr(OP_ADDI, 0, 0);
`ifdef MC_ADDI_EN
        check("addi_len", 32'(plan.size() - base), 32'd4);
`else
        check("addi_len", 32'(plan.size() - base), 32'd2);
`endif
        base = plan.size(); add_instr(OP_SW, 0, 20);
        check("sw_long_len", 32'(plan.size() - base), 32'd24);
        check("sw_long_tmo_count", 32'(count_tmo(base)), 32'd1);
        check("sw_long_tmo_pos", 32'(plan[base + 18].tmo), 32'd1);
        base = plan.size(); add_instr(OP_SW, 0, 14);
        check("sw14_tmo_count", 32'(count_tmo(base)), 32'd0);
        base = plan.size(); add_instr(OP_SW, 0, 15);
        check("sw15_tmo_last", 32'(plan[plan.size() - 1].tmo), 32'd1);
        base = plan.size(); add_instr(OP_J, 0, 0);   check("j_len", 32'(plan.size() - base), 32'd3);

        // lw aborted by a one-cycle reset while in MEMRD, then a jump
        add_step(1'b0, ST_FETCH, 1'b1, OP_LW, 1'b0);
        add_step(1'b0, ST_DECODE, 1'b0, OP_LW, 1'b0);
        add_step(1'b0, ST_MEMADR, 1'b1, OP_LW, 1'b0);
        add_step(1'b0, ST_MEMRD, 1'b0, OP_LW, 1'b0);
        add_step(1'b1, ST_MEMRD, 1'b1, OP_LW, 1'b0);
        add_instr(OP_J, 0, 0);
        add_instr(OP_R, 1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < plan.size(); i++) begin
            cur       = plan[i];
            reset     = plan[i].rst;
            opcode    = plan[i].op;
            mem_ready = plan[i].rdy;
            cur_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle MIPS main control FSM; sits directly upstream of the ALU control decoder and drives its 2-bit ALUop.
- Sequences fetch, decode, execute, memory and writeback steps per instruction from the 6-bit opcode.
- Emits all datapath mux selects and write strobes.
- Holds in memory states until the memory handshake completes.

Parameters:
- MEM_WAIT_MAX, 15, maximum wait cycles tolerated in any memory state before mem_timeout pulses; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26], taken from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_op  out  2  to ALU control: 00 add, 01 subtract, 10 use funct
- alu_src_a  out  1  0 = PC, 1 = regfile A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_source  out  2  00 = ALU result, 01 = ALUOut reg, 10 = jump target
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write if ALU zero
- illegal_op  out  1  one-cycle pulse, unknown opcode in DECODE
- mem_timeout  out  1  one-cycle pulse, wait limit exceeded
- state  out  4  current state code, for debug

Behaviour:
- State register updates on the rising clk edge.
- Reset: state = FETCH (0). While reset is high, all strobes (mem_read, mem_write, ir_write, reg_write, pc_write, pc_write_cond, illegal_op, mem_timeout) are forced to 0 and all selects to 0.
- Reset asserted mid-instruction aborts it; the next cycle is FETCH and no partial write occurs.
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000 (optional feature only)
- States and outputs:
  - FETCH(0): iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write assert only in the cycle mem_ready=1. Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state: lw/sw -> MEMADR; R-type -> EXEC; beq -> BRANCH; j -> JUMP; anything else -> illegal_op=1, then FETCH.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): iord=1, mem_read=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR(5): iord=1, mem_write=1. Holds until mem_ready=1, then goes to FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB(7): reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1. Next: FETCH.
  - JUMP(9): pc_source=10, pc_write=1. Next: FETCH.
- Latency with mem_ready held high: lw 5 cycles, sw 4, R-type 4, beq 3, j 3. Each wait cycle adds 1.
- Outputs are Moore decodes of state; the only mem_ready-dependent outputs are ir_write and pc_write in FETCH.
- opcode is sampled in DECODE and MEMADR only; it must remain stable from FETCH completion until the instruction returns to FETCH.
- Wait counter:
  - Clears on entry to each memory state and increments each cycle mem_ready=0 while in that state.
  - When it reaches MEM_WAIT_MAX, mem_timeout pulses for 1 cycle.
  - The state does not change on timeout; the FSM keeps waiting.
- Unused selects are driven to 0, never X.

Optional Feature:
- MC_ADDI_EN defined:
  - opcode 001000 in DECODE -> ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIEX -> ADDIWB(11): reg_dst=0, mem_to_reg=0, reg_write=1.
  - ADDIWB -> FETCH. addi latency is 4 cycles.
- MC_ADDI_EN undefined: 001000 is illegal (illegal_op pulse, back to FETCH); states 10 and 11 do not exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - 4-bit state codes
  - opcode constants
  - ALUop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - alu_src_b and pc_source select codes
- One natural sub-module, mc_ctrl_outdec: purely combinational state + mem_ready -> control-vector decoder.
- The FSM and the wait counter stay in the top module.

Test Plan:
- lw, mem_ready=1 always -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1; alu_op=00 throughout.
- R-type then beq, mem_ready=1 -> R-type: alu_op=10 in state 6, reg_write with reg_dst=1 in state 7. beq: state 8 with alu_op=01, pc_write_cond=1, 3 cycles total.
- FETCH with mem_ready low 3 cycles, then high -> ir_write/pc_write=0 for 3 cycles, =1 on cycle 4, DECODE on cycle 5.
- opcode 111111 -> illegal_op=1 for exactly 1 cycle in DECODE, then FETCH; no write strobes asserted.
- MEMWR with mem_ready low, MEM_WAIT_MAX=15 -> mem_timeout pulses once after 15 wait cycles; stays in state 5; exits to FETCH when mem_ready rises.
- reset=1 for 1 cycle while in MEMRD -> next state 0, all strobes 0 during reset; j then completes in 3 cycles with pc_source=10.
